// File: rtl/pll_seq_pkg.sv
// Shared types and default-derived sizing for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    PWRDN     = 3'd4,
    FAULT     = 3'd5
  } seq_state_t;

  localparam int unsigned DEF_RST_CYCLES    = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRIES   = 3;

  localparam int unsigned DEF_RST_W     = $clog2(DEF_RST_CYCLES);
  localparam int unsigned DEF_TIMEOUT_W = $clog2(DEF_LOCK_TIMEOUT);
  localparam int unsigned DEF_STABLE_W  = $clog2(DEF_STABLE_CYCLES);
  localparam int unsigned DEF_RETRY_W   = $clog2(DEF_MAX_RETRIES + 1);

  // Counter width for a terminal count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit status inputs.
module sync_2ff (
  input  logic clkref,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clkref or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// PLL reset/lock qualification sequencer with retry and loss-of-lock recovery.
// PLL_LOCK_SEQ_LOSS_CNT_EN adds loss_cnt and last_fault_retry debug outputs.
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       clkref,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       pwrdwn_req,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       pll_pwrdwn,
  output logic       clk_ready,
  output logic       fault,
  output logic [2:0] state_o
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt,
  output logic [1:0] last_fault_retry
`endif
);

  localparam int unsigned CNT_W   = max3(cnt_width(RST_CYCLES), cnt_width(LOCK_TIMEOUT),
                                         cnt_width(STABLE_CYCLES));
  localparam int unsigned RETRY_W = cnt_width(MAX_RETRIES + 1);

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               locked_s;
  logic               restart_c;
  logic               lock_lost_c;
  logic               pll_rst_q, pll_pwrdwn_q, clk_ready_q, fault_q;

  sync_2ff u_lock_sync (
    .clkref  (clkref),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  always_ff @(posedge clkref or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Next state: power-down beats relock beats normal sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    retry_d     = retry_q;
    restart_c   = 1'b0;
    lock_lost_c = 1'b0;
    if (pwrdwn_req && (state_q != FAULT)) begin
      state_d   = PWRDN;
      restart_c = 1'b1;
    end else if (relock_req) begin
      state_d   = RST_HOLD;
      retry_d   = '0;
      restart_c = 1'b1;
    end else begin
      case (state_q)
        RST_HOLD: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = (retry_d == RETRY_W'(MAX_RETRIES)) ? FAULT : RST_HOLD;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d     = RST_HOLD;
            lock_lost_c = 1'b1;
          end
        end
        PWRDN: begin
          if (!pwrdwn_req) state_d = RST_HOLD;
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RST_HOLD;
        end
      endcase
    end
    if ((state_d != state_q) || restart_c) cnt_d = '0;
  end

  // Outputs decoded from the next state so they change with the state register.
  always_ff @(posedge clkref or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst_q    <= 1'b1;
      pll_pwrdwn_q <= 1'b0;
      clk_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      pll_rst_q    <= (state_d == RST_HOLD) || (state_d == PWRDN) || (state_d == FAULT);
      pll_pwrdwn_q <= (state_d == PWRDN);
      clk_ready_q  <= (state_d == RUN);
      fault_q      <= (state_d == FAULT);
    end
  end

  assign pll_rst    = pll_rst_q;
  assign pll_pwrdwn = pll_pwrdwn_q;
  assign clk_ready  = clk_ready_q;
  assign fault      = fault_q;
  assign state_o    = state_q;

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;
  logic [1:0] last_fault_retry_q;

  always_ff @(posedge clkref or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt_q         <= '0;
      last_fault_retry_q <= '0;
    end else begin
      if (lock_lost_c && (loss_cnt_q != 8'hFF)) loss_cnt_q <= loss_cnt_q + 8'd1;
      if ((state_d == FAULT) && (state_q != FAULT)) last_fault_retry_q <= 2'(retry_d);
    end
  end

  assign loss_cnt         = loss_cnt_q;
  assign last_fault_retry = last_fault_retry_q;
`endif

endmodule
